// File: rtl/fpga_reset_sequencer_if.sv
// Board-side signal bundle of the FPGA reset sequencer.
// The sequencer uses the slave view; the board/test side uses the master view.
interface fpga_reset_sequencer_if;
    logic       btn_i;
    logic       locked_i;
    logic       rst_no;
    logic       btn_db_o;
    logic [1:0] state_o;
    logic [7:0] rst_cnt_o;

    modport master (
        output btn_i,
        output locked_i,
        input  rst_no,
        input  btn_db_o,
        input  state_o,
        input  rst_cnt_o
    );

    modport slave (
        input  btn_i,
        input  locked_i,
        output rst_no,
        output btn_db_o,
        output state_o,
        output rst_cnt_o
    );
endinterface

// File: rtl/fpga_reset_sequencer.sv
// Board-level reset conditioner: synchronises and debounces the reset button,
// watches clock lock, and releases a clean active-low SoC reset after a hold time.
module fpga_reset_sequencer #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 125000,
    parameter int unsigned HOLD_CYCLES     = 256
) (
    input logic                   clk_i,
    input logic                   rst_ni,
    fpga_reset_sequencer_if.slave bus
);

    localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        LOCK_WAIT = 2'b00,
        HOLD      = 2'b01,
        RUN       = 2'b10
    } state_t;

    logic [SYNC_STAGES-1:0] btn_sync;
    logic [SYNC_STAGES-1:0] lock_sync;
    logic                   btn_s;
    logic                   lock_s;
    logic [DW-1:0]          db_cnt;
    logic                   btn_db;
    logic [HW-1:0]          hold_cnt;
    state_t                 state;
    state_t                 state_next;
    logic                   hold_inc;
    logic                   hold_clr;
    logic                   ok;
    logic                   count_evt;
    logic                   rst_q;
    logic [7:0]             rst_cnt;

    assign btn_s  = btn_sync[SYNC_STAGES-1];
    assign lock_s = lock_sync[SYNC_STAGES-1];
    assign ok     = lock_s & ~btn_db;

    // Bring the asynchronous button and lock pads into the clk_i domain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            btn_sync  <= '0;
            lock_sync <= '0;
        end else begin
            btn_sync  <= {btn_sync[SYNC_STAGES-2:0], bus.btn_i};
            lock_sync <= {lock_sync[SYNC_STAGES-2:0], bus.locked_i};
        end
    end

    // Accept a new button level only after it has been stable long enough.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            db_cnt <= '0;
            btn_db <= 1'b0;
        end else if (btn_s == btn_db) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            db_cnt <= '0;
            btn_db <= btn_s;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    // Next-state and hold-counter control for the reset sequencing FSM.
    always_comb begin
        state_next = state;
        hold_inc   = 1'b0;
        hold_clr   = 1'b0;
        case (state)
            LOCK_WAIT: begin
                hold_clr = 1'b1;
                if (ok) state_next = HOLD;
            end
            HOLD: begin
                if (!ok) begin
                    state_next = LOCK_WAIT;
                    hold_clr   = 1'b1;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_next = RUN;
                end else begin
                    hold_inc = 1'b1;
                end
            end
            RUN: begin
                if (!ok) state_next = LOCK_WAIT;
            end
            default: begin
                state_next = LOCK_WAIT;
                hold_clr   = 1'b1;
            end
        endcase
    end

    assign count_evt = (state == RUN) && !ok && btn_db;

    // State, hold counter and the registered reset output (no input-to-output path).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= LOCK_WAIT;
            hold_cnt <= '0;
            rst_q    <= 1'b0;
        end else begin
            state <= state_next;
            rst_q <= (state_next == RUN);
            if (hold_clr) begin
                hold_cnt <= '0;
            end else if (hold_inc) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

    // Count button-caused drops out of RUN, saturating at 255.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rst_cnt <= '0;
        end else if (count_evt && rst_cnt != 8'hFF) begin
            rst_cnt <= rst_cnt + 8'd1;
        end
    end

    assign bus.rst_no    = rst_q;
    assign bus.btn_db_o  = btn_db;
    assign bus.state_o   = state;
    assign bus.rst_cnt_o = rst_cnt;

endmodule

// File: tb/tb_fpga_reset_sequencer.sv
// Randomised and directed bench for the FPGA reset sequencer, checked every
// cycle against a run-length / window model of the conditioning rules.
module tb_fpga_reset_sequencer;

    localparam int S = 2;
    localparam int D = 4;
    localparam int H = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    fpga_reset_sequencer_if bus ();

    fpga_reset_sequencer #(
        .SYNC_STAGES    (S),
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES    (H)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model: delay lines for the synchronisers, a window of the last D synced
    // button samples, and the length of the current run of "ok" cycles.
    bit lock_d [S];
    bit btn_d  [S];
    bit dh     [D];
    bit m_db;
    int m_run;
    int m_cnt;
    bit m_ok;
    bit m_was_run;
    bit m_all;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < S; i++) begin
                lock_d[i] = 1'b0;
                btn_d[i]  = 1'b0;
            end
            for (int i = 0; i < D; i++) dh[i] = 1'b0;
            m_db  = 1'b0;
            m_run = 0;
            m_cnt = 0;
        end else begin
            m_ok      = lock_d[S-1] & ~m_db;
            m_was_run = (m_run > H);
            if (m_ok) m_run = (m_run > H) ? H + 1 : m_run + 1;
            else m_run = 0;
            if (m_was_run && !m_ok && m_db && m_cnt < 255) m_cnt++;
            for (int i = D - 1; i > 0; i--) dh[i] = dh[i-1];
            dh[0] = btn_d[S-1];
            m_all = 1'b1;
            for (int i = 0; i < D; i++) if (dh[i] == m_db) m_all = 1'b0;
            if (m_all) m_db = ~m_db;
            for (int i = S - 1; i > 0; i--) begin
                lock_d[i] = lock_d[i-1];
                btn_d[i]  = btn_d[i-1];
            end
            lock_d[0] = bus.locked_i;
            btn_d[0]  = bus.btn_i;
        end
    end

    logic       e_rst;
    logic [1:0] e_state;

    always_comb begin
        e_rst   = (m_run > H);
        e_state = (m_run == 0) ? 2'd0 : ((m_run <= H) ? 2'd1 : 2'd2);
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            vectors++;
            if (bus.rst_no !== e_rst || bus.state_o !== e_state ||
                bus.btn_db_o !== m_db || bus.rst_cnt_o !== 8'(m_cnt)) begin
                miscompares++;
                $display("FAIL model t=%0t got rst=%b st=%0d db=%b cnt=%0d want rst=%b st=%0d db=%b cnt=%0d",
                         $time, bus.rst_no, bus.state_o, bus.btn_db_o, bus.rst_cnt_o,
                         e_rst, e_state, m_db, m_cnt);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int lo, input int hi);
        vectors++;
        if (act < lo || act > hi) begin
            miscompares++;
            $display("FAIL %s got %0d want %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic wait_rst(input logic val, input int budget, output int n);
        n = 0;
        while (bus.rst_no !== val && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_state(input logic [1:0] val, input int budget, output int n);
        n = 0;
        while (bus.state_o !== val && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    int n;
    int k;
    int c0;

    initial begin
        bus.btn_i    = 1'b0;
        bus.locked_i = 1'b1;
        rst_n        = 1'b0;
        cyc(3);
        chk("reset_rst_no", int'(bus.rst_no), 0, 0);
        chk("reset_state", int'(bus.state_o), 0, 0);
        chk("reset_cnt", int'(bus.rst_cnt_o), 0, 0);
        rst_n = 1'b1;

        // Boot
        wait_rst(1'b1, 50, n);
        chk("boot_latency", n, 10, 12);
        chk("boot_state", int'(bus.state_o), 2, 2);

        // Short glitch is filtered
        c0 = int'(bus.rst_cnt_o);
        bus.btn_i = 1'b1;
        cyc(3);
        bus.btn_i = 1'b0;
        cyc(15);
        chk("glitch_rst_no", int'(bus.rst_no), 1, 1);
        chk("glitch_db", int'(bus.btn_db_o), 0, 0);
        chk("glitch_cnt", int'(bus.rst_cnt_o), c0, c0);

        // Real press
        bus.btn_i = 1'b1;
        wait_rst(1'b0, 30, n);
        chk("press_assert", n, 5, 8);
        cyc(20 - n);
        bus.btn_i = 1'b0;
        wait_rst(1'b1, 60, n);
        chk("press_release", n, 13, 17);
        chk("press_count", int'(bus.rst_cnt_o), 1, 1);

        // One-cycle lock loss
        bus.locked_i = 1'b0;
        cyc(1);
        bus.locked_i = 1'b1;
        wait_rst(1'b0, 10, n);
        chk("lock_assert", n + 1, 1, 4);
        wait_rst(1'b1, 40, n);
        chk("lock_release", n, 7, 11);
        chk("lock_count", int'(bus.rst_cnt_o), 1, 1);

        // Hold interrupted at hold_cnt=5 must restart the full hold
        bus.locked_i = 1'b0;
        cyc(1);
        bus.locked_i = 1'b1;
        wait_state(2'd1, 20, n);
        chk("hold_entry", n, 1, 19);
        cyc(3);
        bus.locked_i = 1'b0;
        cyc(1);
        bus.locked_i = 1'b1;
        wait_rst(1'b1, 40, n);
        chk("hold_restart", n, 10, 12);

        // Random traffic
        for (int it = 0; it < 300; it++) begin
            k = $urandom_range(0, 9);
            if (k < 3) begin
                bus.btn_i = 1'b1;
                cyc($urandom_range(1, 8));
                bus.btn_i = 1'b0;
            end else if (k < 5) begin
                bus.locked_i = 1'b0;
                cyc($urandom_range(1, 4));
                bus.locked_i = 1'b1;
            end else if (k == 5 && $urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #2 rst_n = 1'b0;
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
            end
            cyc($urandom_range(1, 20));
        end
        bus.btn_i    = 1'b0;
        bus.locked_i = 1'b1;
        cyc(40);

        // Saturation of the button reset counter
        wait_rst(1'b1, 60, n);
        for (int p = 0; p < 260; p++) begin
            bus.btn_i = 1'b1;
            cyc(8);
            bus.btn_i = 1'b0;
            wait_rst(1'b1, 40, n);
        end
        cyc(2);
        chk("sat_count", int'(bus.rst_cnt_o), 255, 255);
        chk("sat_rst_no", int'(bus.rst_no), 1, 1);

        // Asynchronous reset mid-RUN, checked with no clock edge in between
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_no", int'(bus.rst_no), 0, 0);
        chk("async_cnt", int'(bus.rst_cnt_o), 0, 0);
        chk("async_state", int'(bus.state_o), 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_rst(1'b1, 50, n);
        chk("reboot_latency", n, 10, 12);
        cyc(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
